regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 92 +++++++++
 tb/tb_regfile_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_READ async read ports, one sync write port, optional zero entry, bulk-clear sweep.
// Reads combinational, writes land next cycle; writes dropped while ClearBusy. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
  output logic [NUM_READ*WIDTH-1:0]    ReadData,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic                         RegWrite,
  input  logic                         ClearReq,
  output logic                         ClearBusy,
  output logic                         ClearDone
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_zero;
  logic              wr_fire;

  assign wr_zero = (ZERO_REG != 0) && (WriteRegister == '0);
  assign wr_fire = RegWrite && (state == IDLE) && !wr_zero;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      sweep_idx <= '0;
      ClearBusy <= 1'b0;
      ClearDone <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ClearDone <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with a clear request still lands; the sweep zeroes it later.
          if (wr_fire) begin
            mem[WriteRegister] <= WriteData;
          end
          if (ClearReq) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            ClearBusy <= 1'b1;
          end
        end
        SWEEP: begin
          mem[sweep_idx] <= '0;
          sweep_idx      <= sweep_idx + ADDR_W'(1);
          if (sweep_idx == ADDR_W'(DEPTH - 1)) begin
            state     <= IDLE;
            ClearBusy <= 1'b0;
            ClearDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd;

    assign ra = ReadRegister[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (ra == WriteRegister)) begin
        rd = WriteData;
      end
`else
`endif
    end

    assign ReadData[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 32x32/2-port/zero-reg instance plus a 16x8/3-port instance without zero reg.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en, clr_req, clr_busy, clr_done;

  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_wr_en, b_clr_req, b_busy, b_done;

  regfile_param dut (
    .Clk(clk), .Reset_n(rst_n),
    .ReadRegister(rd_addr), .ReadData(rd_data),
    .WriteRegister(wr_addr), .WriteData(wr_data), .RegWrite(wr_en),
    .ClearReq(clr_req), .ClearBusy(clr_busy), .ClearDone(clr_done)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .NUM_READ(3), .ZERO_REG(0)) dut_b (
    .Clk(clk), .Reset_n(rst_n),
    .ReadRegister(b_rd_addr), .ReadData(b_rd_data),
    .WriteRegister(b_wr_addr), .WriteData(b_wr_data), .RegWrite(b_wr_en),
    .ClearReq(b_clr_req), .ClearBusy(b_busy), .ClearDone(b_done)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input string tag, input int p, input logic [4:0] a, input logic [31:0] want);
    rd_addr[p*5 +: 5] = a;
    push(tag, want);
    #1;
    pop_chk(rd_data[p*32 +: 32]);
  endtask

  task automatic brd(input string tag, input int p, input logic [2:0] a, input logic [15:0] want);
    b_rd_addr[p*3 +: 3] = a;
    push(tag, {16'h0, want});
    #1;
    pop_chk({16'h0, b_rd_data[p*16 +: 16]});
  endtask

  task automatic sig(input string tag, input logic obs, input logic want);
    push(tag, {31'h0, want});
    pop_chk({31'h0, obs});
  endtask

  task automatic cnt_chk(input string tag, input int obs, input int want);
    push(tag, 32'(want));
    pop_chk(32'(obs));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!clr_done && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    rst_n = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_en = 1'b0; clr_req = 1'b0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = 1'b0; b_clr_req = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();

    sig("rst_busy", clr_busy, 1'b0);
    sig("rst_done", clr_done, 1'b0);
    rd("rst_rd7_p0", 0, 5'd7, 32'h0);
    rd("rst_rd7_p1", 1, 5'd7, 32'h0);
    brd("b_rst_rd3", 0, 3'd3, 16'h0);
    step();
    rst_n = 1'b1;
    step();

    // Basic write to entry 7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    rd("wr7_same_cycle", 0, 5'd7, BYP ? 32'hDEADBEEF : 32'h0);
    step();
    wr_en = 1'b0;
    rd("wr7_p0", 0, 5'd7, 32'hDEADBEEF);
    rd("wr7_p1", 1, 5'd7, 32'hDEADBEEF);
    rd("other_p0", 0, 5'd8, 32'h0);
    rd("other_p1", 1, 5'd31, 32'h0);

    // Entry 0 is hardwired to zero
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rd("zero_same_cycle", 0, 5'd0, 32'h0);
    step();
    wr_en = 1'b0;
    rd("zero_p0", 0, 5'd0, 32'h0);
    rd("zero_p1", 1, 5'd0, 32'h0);

    // Forwarding on port 1 only; port 0 reads an unrelated entry
    wr(5'd3, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    rd("byp_p1_same", 1, 5'd3, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    rd("byp_p0_other", 0, 5'd7, 32'hDEADBEEF);
    step();
    wr_en = 1'b0;
    rd("byp_p1_next", 1, 5'd3, 32'hA5A5A5A5);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rd("fill31", 0, 5'd31, 32'd31);
    rd("fill5", 1, 5'd5, 32'd5);

    // Full sweep with a dropped write and an ignored re-request
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (c == 3) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; clr_req = 1'b1;
      end
      if (c == 4) begin
        wr_en = 1'b0; clr_req = 1'b0;
        rd("sweep_drop5", 1, 5'd5, 32'd5);
        rd("sweep_swept2", 0, 5'd2, 32'h0);
      end
      if (c == 11) begin
        rd("sweep_mid9", 0, 5'd9, 32'h0);
        rd("sweep_mid10", 1, 5'd10, 32'd10);
      end
      step();
    end
    cnt_chk("sweep_busy_cycles", busy_cnt, 32);
    cnt_chk("sweep_done_pulses", done_cnt, 1);
    for (int i = 0; i < 32; i++) rd("swept_zero", i % 2, 5'(i), 32'h0);

    // Write and clear request on the same edge
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77; clr_req = 1'b1;
    step();
    wr_en = 1'b0; clr_req = 1'b0;
    sig("wc_busy", clr_busy, 1'b1);
    rd("wc_written", 0, 5'd9, 32'h77);
    wait_done();
    sig("wc_done_seen", clr_done, 1'b1);
    rd("wc_cleared", 0, 5'd9, 32'h0);

    // Request held across ClearDone restarts on the next idle edge
    clr_req = 1'b1;
    step();
    wait_done();
    sig("held_done", clr_done, 1'b1);
    sig("held_busy_low", clr_busy, 1'b0);
    step();
    sig("held_restart", clr_busy, 1'b1);
    clr_req = 1'b0;
    wait_done();
    sig("held_done2", clr_done, 1'b1);
    step();

    // Reset in the middle of a sweep
    wr(5'd12, 32'hC);
    wr(5'd30, 32'h1E);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    rd("pre_rst_12", 0, 5'd12, 32'hC);
    rst_n = 1'b0;
    #1;
    sig("rst_mid_busy", clr_busy, 1'b0);
    rd("rst_mid_12", 0, 5'd12, 32'h0);
    rd("rst_mid_30", 1, 5'd30, 32'h0);
    done_cnt = 0;
    repeat (3) begin
      step();
      if (clr_done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      step();
      if (clr_done) done_cnt++;
    end
    cnt_chk("rst_no_done", done_cnt, 0);
    sig("rst_idle_busy", clr_busy, 1'b0);

    // Narrow, shallow, three-port instance with an ordinary entry 0
    b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 16'hBEEF;
    step();
    b_wr_en = 1'b0;
    brd("b_rd0_p0", 0, 3'd0, 16'hBEEF);
    brd("b_rd0_p1", 1, 3'd0, 16'hBEEF);
    brd("b_rd0_p2", 2, 3'd0, 16'hBEEF);
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (12) begin
      if (b_busy) busy_cnt++;
      if (b_done) done_cnt++;
      step();
    end
    cnt_chk("b_sweep_busy_cycles", busy_cnt, 8);
    cnt_chk("b_sweep_done_pulses", done_cnt, 1);
    brd("b_cleared", 1, 3'd0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
